ascon_bdi_packer: RTL and testbench
===================================

Name: ascon_bdi_packer

Overview:
- Host-side transmitter for the Ascon core's input interfaces: mode, key and bdi.
- Takes a byte stream in which every byte is tagged with a segment type (key, nonce, AD, message, tag) and packs it into CCW-bit words.
- For each word it drives key/key_valid or bdi/bdi_valid (byte enables), plus bdi_type, bdi_eot and bdi_eoi.
- It issues the one-cycle mode request that starts an operation, then waits for the core's done flag before accepting the next command.

Parameters:
- CCW, 32, core word width in bits (32 or 64).
- CCWD8, CCW/8, bytes per word; also the width of bdi_valid.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_mode  in  4  operation: M_ENC, M_DEC, M_HASH, M_XOF or M_CXOF
- cmd_empty  in  1  operation carries no input bytes (hash/XOF of the empty message)
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- in_data  in  8  input byte
- in_type  in  4  segment type of the byte: D_KEY, D_NONCE, D_AD, D_MSG or D_TAG
- in_last  in  1  last byte of the current segment
- in_final  in  1  last byte of the whole operation
- in_valid  in  1  byte valid
- in_ready  out  1  byte accepted when in_valid & in_ready
- mode  out  4  mode request to the core
- key  out  CCW  key word
- key_valid  out  1  key word valid
- key_ready  in  1  core accepts the key word
- bdi  out  CCW  data word
- bdi_valid  out  CCWD8  byte enables for bdi
- bdi_ready  in  1  core accepts the data word
- bdi_type  out  4  type of the data word
- bdi_eot  out  1  data word ends its segment
- bdi_eoi  out  1  data word ends the operation's input
- done  in  1  core done flag (level)
- busy  out  1  an operation is in progress

Behaviour:
- Reset (rst_n low, asynchronous):
  - fsm=IDLE; assembly and output registers cleared.
  - cmd_ready=1; in_ready=0; mode=0; key_valid=0; bdi_valid=0; bdi_type=D_NULL; bdi_eot=0; bdi_eoi=0; busy=0.
- Byte order: byte k of a word sits at bits [8k+7:8k], filled from k=0 upward. bdi_valid bit k is set for each filled byte, so enables are always contiguous from the LSB.
- Assembly register:
  - Collects accepted bytes.
  - A word's type, eot and eoi come from its first byte and its closing byte respectively; in_type of later bytes in the same word is ignored.
  - A word closes when CCWD8 bytes have been collected or when the accepted byte has in_last=1. in_final implies in_last.
  - Unused bytes of a closed word are zero.
- Output register (one entry) holds the closed word.
  - A closed word moves from assembly to the output register in the cycle after its closing byte is accepted, if the output register is empty or is being consumed in that cycle.
  - Latency: closing byte accepted at cycle t -> word visible at t+1.
  - in_ready = (fsm==STREAM) & !(assembly closed & output register held).
  - Throughput: one byte per cycle with no stalls while the core accepts.
- Output routing:
  - Type D_KEY: drives key; key_valid=1; bdi_valid=0; bdi_type=D_NULL.
  - Any other type: drives bdi, bdi_valid=enables, bdi_type, bdi_eot, bdi_eoi.
  - Output register empty: bdi_valid=0, bdi_type=D_NULL, key_valid=0. This is mandatory because the core samples a tag on bdi_type alone.
  - The word retires when (key_valid & key_ready) or (bdi_valid!=0 & bdi_ready). Outputs are held stable until the word retires.
- FSM:
  - IDLE: cmd_ready=1. On command accept, latch mode_r and empty_r, set busy=1, then:
    - empty_r=1 -> EMPTY.
    - otherwise -> STREAM.
  - STREAM:
    - Before the first word of the operation reaches the output register, mode=0.
    - In the first cycle that word is present, mode=mode_r for exactly one cycle. For AEAD the key word, if present, is therefore already valid when the core samples mode.
    - After the output register retires the word with eoi=1 -> WAIT_DONE.
  - EMPTY: mode=mode_r and bdi_eoi=1 for one cycle, then -> WAIT_DONE.
  - WAIT_DONE:
    - Set done_low once done==0 has been seen after the mode pulse.
    - When done==1 & done_low -> IDLE, busy=0.
- Boundary conditions:
  - cmd_valid outside IDLE is ignored.
  - in_valid in IDLE or WAIT_DONE is not accepted.
  - A byte with in_last and a full word on the same byte closes the word once (eot=1), not twice.
  - Reset mid-operation aborts immediately; no partial word is emitted after reset.

Test Plan:
- CCW=32, M_ENC: 16 key bytes 00..0F, 16 nonce bytes 10..1F (last), 3 AD bytes AA BB CC (last), 4 msg bytes 01 02 03 04 (last, final) -> the following, with mode=M_ENC pulsed exactly one cycle while key_valid=1:
  - key words 0x03020100 .. 0x0F0E0D0C;
  - four D_NONCE words, eot=1 on the 4th;
  - D_AD bdi=0x00CCBBAA, bdi_valid=0b0111, eot=1;
  - D_MSG 0x04030201, valid=0xF, eot=1, eoi=1.
- bdi_ready held low 10 cycles while a word is pending -> bdi, bdi_valid, bdi_type, bdi_eot and bdi_eoi remain stable; in_ready drops once the next word has closed.
- cmd_empty=1, M_HASH -> single mode pulse with bdi_eoi=1 and bdi_valid=0; busy stays 1 until done rises, then cmd_ready=1.
- M_DEC with tag bytes after the message -> bdi_type=D_NULL in every cycle where no tag word is pending; tag words carry D_TAG with eot=1 and eoi=1 on the last.
- rst_n asserted during STREAM with 2 bytes assembled -> all outputs at reset values asynchronously; the next operation's first word contains no stale bytes.

Source files
------------

// File: rtl/ascon_bdi_packer.sv
`timescale 1ns/1ps
// Packs a type-tagged byte stream into CCW-bit key/bdi words for the Ascon core,
// issues the one-cycle mode request and waits for the core's done flag.
module ascon_bdi_packer #(
    parameter int CCW   = 32,
    parameter int CCWD8 = CCW / 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       cmd_mode,
    input  logic             cmd_empty,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       in_data,
    input  logic [3:0]       in_type,
    input  logic             in_last,
    input  logic             in_final,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [3:0]       mode,
    output logic [CCW-1:0]   key,
    output logic             key_valid,
    input  logic             key_ready,
    output logic [CCW-1:0]   bdi,
    output logic [CCWD8-1:0] bdi_valid,
    input  logic             bdi_ready,
    output logic [3:0]       bdi_type,
    output logic             bdi_eot,
    output logic             bdi_eoi,
    input  logic             done,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    // Segment encodings: D_NULL=0 D_AD=1 D_MSG=2 D_TAG=3 D_NONCE=4 D_KEY=5
    localparam logic [3:0] D_NULL = 4'd0;
    localparam logic [3:0] D_KEY  = 4'd5;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_STREAM    = 2'd1;
    localparam logic [1:0] S_EMPTY     = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    localparam int CW = $clog2(CCWD8 + 1);

    // Handshakes: every transfer happens on a rising edge where valid & ready are
    // both high; a valid word is held unchanged until that edge.

    logic [1:0]       fsm;
    logic [3:0]       mode_r;
    logic             empty_r;
    logic             mode_sent;
    logic             done_low;

    logic [CCW-1:0]   asm_data;
    logic [CW-1:0]    asm_cnt;
    logic [3:0]       asm_type;
    logic             asm_eot;
    logic             asm_eoi;
    logic             asm_closed;

    logic [CCW-1:0]   out_data;
    logic [CCWD8-1:0] out_en;
    logic [3:0]       out_type;
    logic             out_eot;
    logic             out_eoi;
    logic             out_full;

    logic             out_is_key;
    logic             bdi_word;
    logic             out_retire;
    logic             out_free;
    logic             in_fire;
    logic             cmd_fire;
    logic [CW-1:0]    base_cnt;
    logic [CCW-1:0]   base_data;
    logic [CCW-1:0]   new_data;
    logic [CW-1:0]    new_cnt;
    logic [3:0]       new_type;
    logic             new_close;
    logic             load_from_asm;
    logic             load_from_in;

    function automatic logic [CCWD8-1:0] en_mask(input logic [CW-1:0] n);
        logic [CCWD8-1:0] m;
        m = '0;
        for (int k = 0; k < CCWD8; k++) m[k] = (CW'(k) < n);
        return m;
    endfunction

    assign out_is_key = (out_type == D_KEY);
    assign bdi_word   = out_full & ~out_is_key;
    assign out_retire = out_full & (out_is_key ? key_ready : bdi_ready);
    assign out_free   = ~out_full | out_retire;
    assign in_ready   = (fsm == S_STREAM) & ~(asm_closed & out_full);
    assign in_fire    = in_valid & in_ready;
    assign cmd_ready  = (fsm == S_IDLE);
    assign cmd_fire   = cmd_valid & cmd_ready;

    // A closed word still in assembly is handed over this cycle, so a new byte starts fresh.
    assign base_cnt  = asm_closed ? '0 : asm_cnt;
    assign base_data = asm_closed ? '0 : asm_data;
    assign new_cnt   = base_cnt + CW'(1);
    assign new_type  = (base_cnt == '0) ? in_type : asm_type;
    assign new_close = (new_cnt == CW'(CCWD8)) | in_last | in_final;

    always_comb begin
        new_data = base_data;
        for (int k = 0; k < CCWD8; k++) begin
            if (base_cnt == CW'(k)) new_data[8*k +: 8] = in_data;
        end
    end

    assign load_from_asm = asm_closed & out_free;
    assign load_from_in  = in_fire & new_close & ~asm_closed & out_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            asm_data   <= '0;
            asm_cnt    <= '0;
            asm_type   <= D_NULL;
            asm_eot    <= 1'b0;
            asm_eoi    <= 1'b0;
            asm_closed <= 1'b0;
            out_data   <= '0;
            out_en     <= '0;
            out_type   <= D_NULL;
            out_eot    <= 1'b0;
            out_eoi    <= 1'b0;
            out_full   <= 1'b0;
        end else begin
            if (load_from_asm) begin
                out_data <= asm_data;
                out_en   <= en_mask(asm_cnt);
                out_type <= asm_type;
                out_eot  <= asm_eot;
                out_eoi  <= asm_eoi;
                out_full <= 1'b1;
            end else if (load_from_in) begin
                out_data <= new_data;
                out_en   <= en_mask(new_cnt);
                out_type <= new_type;
                out_eot  <= in_last | in_final;
                out_eoi  <= in_final;
                out_full <= 1'b1;
            end else if (out_retire) begin
                out_full <= 1'b0;
            end

            if (in_fire && !load_from_in) begin
                asm_data   <= new_data;
                asm_cnt    <= new_cnt;
                asm_type   <= new_type;
                asm_eot    <= in_last | in_final;
                asm_eoi    <= in_final;
                asm_closed <= new_close;
            end else if (load_from_in || load_from_asm) begin
                asm_data   <= '0;
                asm_cnt    <= '0;
                asm_eot    <= 1'b0;
                asm_eoi    <= 1'b0;
                asm_closed <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm       <= S_IDLE;
            mode_r    <= 4'd0;
            empty_r   <= 1'b0;
            mode_sent <= 1'b0;
            done_low  <= 1'b0;
        end else begin
            // done may still be high from the previous operation until the core reacts.
            if (fsm != S_IDLE && mode_sent && !done) done_low <= 1'b1;
            case (fsm)
                S_IDLE: begin
                    if (cmd_fire) begin
                        mode_r    <= cmd_mode;
                        empty_r   <= cmd_empty;
                        mode_sent <= 1'b0;
                        done_low  <= 1'b0;
                        fsm       <= cmd_empty ? S_EMPTY : S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (out_full) mode_sent <= 1'b1;
                    if (out_retire && out_eoi) fsm <= S_WAIT_DONE;
                end
                S_EMPTY: begin
                    mode_sent <= 1'b1;
                    fsm       <= S_WAIT_DONE;
                end
                default: begin
                    if (done && done_low) fsm <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = (fsm != S_IDLE);
    assign dbg_state = fsm;
    assign mode      = (((fsm == S_STREAM) & out_full & ~mode_sent) | (fsm == S_EMPTY))
                       ? mode_r : 4'd0;
    assign key_valid = out_full & out_is_key;
    assign key       = key_valid ? out_data : '0;
    assign bdi       = bdi_word ? out_data : '0;
    assign bdi_valid = bdi_word ? out_en : '0;
    assign bdi_type  = bdi_word ? out_type : D_NULL;
    assign bdi_eot   = bdi_word & out_eot;
    assign bdi_eoi   = (bdi_word & out_eoi) | ((fsm == S_EMPTY) & empty_r);

endmodule

// File: tb/tb_ascon_bdi_packer.sv
`timescale 1ns/1ps
// Directed bench for ascon_bdi_packer: table of word vectors plus hand-written
// stall, empty-hash and mid-operation reset sequences.
module tb_ascon_bdi_packer;
    localparam int CCW   = 32;
    localparam int CCWD8 = 4;

    localparam logic [3:0] D_NULL  = 4'd0;
    localparam logic [3:0] D_AD    = 4'd1;
    localparam logic [3:0] D_MSG   = 4'd2;
    localparam logic [3:0] D_TAG   = 4'd3;
    localparam logic [3:0] D_NONCE = 4'd4;
    localparam logic [3:0] D_KEY   = 4'd5;
    localparam logic [3:0] M_ENC   = 4'd1;
    localparam logic [3:0] M_DEC   = 4'd2;
    localparam logic [3:0] M_HASH  = 4'd3;
    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic             clk, rst_n;
    logic [3:0]       cmd_mode;
    logic             cmd_empty, cmd_valid, cmd_ready;
    logic [7:0]       in_data;
    logic [3:0]       in_type;
    logic             in_last, in_final, in_valid, in_ready;
    logic [3:0]       mode;
    logic [CCW-1:0]   key, bdi;
    logic             key_valid, key_ready, bdi_ready;
    logic [CCWD8-1:0] bdi_valid;
    logic [3:0]       bdi_type;
    logic             bdi_eot, bdi_eoi, done, busy;
    logic [1:0]       dbg_state;

    ascon_bdi_packer #(.CCW(CCW), .CCWD8(CCWD8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_mode(cmd_mode), .cmd_empty(cmd_empty), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .in_data(in_data), .in_type(in_type), .in_last(in_last), .in_final(in_final),
        .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .key(key), .key_valid(key_valid), .key_ready(key_ready),
        .bdi(bdi), .bdi_valid(bdi_valid), .bdi_ready(bdi_ready), .bdi_type(bdi_type),
        .bdi_eot(bdi_eot), .bdi_eoi(bdi_eoi), .done(done), .busy(busy), .dbg_state(dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          n;
        logic [3:0]  typ;
        logic [31:0] bytes;
        logic        last;
        logic        fin;
        logic [31:0] exp_data;
        logic [3:0]  exp_en;
        logic        exp_eot;
        logic        exp_eoi;
    } vec_t;

    vec_t        vecs[0:23];
    logic [41:0] exp_q[$];
    int          checks, errors, mode_cnt, mode_key, stalls;
    logic [3:0]  mode_seen;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Core-side monitor, called once per cycle at the falling edge.
    task automatic monitor();
        logic [41:0] got;
        if (rst_n) begin
            if (mode != 4'd0) begin
                mode_cnt++;
                mode_seen = mode;
                if (key_valid) mode_key++;
            end
            if (bdi_valid == '0) chk("null_type", {60'd0, bdi_type}, {60'd0, D_NULL});
            if (key_valid) chk("key_excl", {60'd0, bdi_valid}, 64'd0);
            if ((key_valid && key_ready) || (bdi_valid != '0 && bdi_ready)) begin
                got = key_valid ? {D_KEY, 1'b0, 1'b0, 4'hF, key}
                                : {bdi_type, bdi_eot, bdi_eoi, bdi_valid, bdi};
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word got=%0h exp=none at %0t", got, $time);
                end else begin
                    chk("word", {22'd0, got}, {22'd0, exp_q.pop_front()});
                end
            end
        end
    endtask

    task automatic half();
        @(negedge clk);
        monitor();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic [3:0] t, input logic l, input logic f);
        int n;
        logic acc;
        in_data = d; in_type = t; in_last = l; in_final = f; in_valid = 1'b1;
        n = 0; acc = 1'b0;
        while (!acc && n < 200) begin
            half();
            acc = in_ready;
            if (!acc) stalls++;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!acc) chk("byte_timeout", 64'd0, 64'd1);
    endtask

    task automatic send_cmd(input logic [3:0] m, input logic e);
        int n;
        logic acc;
        cmd_mode = m; cmd_empty = e; cmd_valid = 1'b1;
        n = 0; acc = 1'b0;
        while (!acc && n < 200) begin
            half();
            acc = cmd_ready;
            tick();
            n++;
        end
        cmd_valid = 1'b0;
        if (!acc) chk("cmd_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            half();
            tick();
            n++;
        end
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic mk(input int i, input int n, input logic [3:0] t, input logic [31:0] b,
                      input logic l, input logic f, input logic [31:0] ed, input logic [3:0] ee,
                      input logic eot, input logic eoi);
        vecs[i].n = n; vecs[i].typ = t; vecs[i].bytes = b; vecs[i].last = l; vecs[i].fin = f;
        vecs[i].exp_data = ed; vecs[i].exp_en = ee; vecs[i].exp_eot = eot; vecs[i].exp_eoi = eoi;
    endtask

    task automatic apply_vecs(input int lo, input int hi);
        logic [31:0] b;
        for (int i = lo; i <= hi; i++) begin
            exp_q.push_back({vecs[i].typ, vecs[i].exp_eot, vecs[i].exp_eoi,
                             vecs[i].exp_en, vecs[i].exp_data});
            b = vecs[i].bytes;
            for (int k = 0; k < vecs[i].n; k++) begin
                send_byte(b[8*k +: 8], vecs[i].typ,
                          (k == vecs[i].n - 1) && vecs[i].last,
                          (k == vecs[i].n - 1) && vecs[i].fin);
            end
        end
    endtask

    task automatic finish_op(input string name);
        done = 1'b1;
        tick();
        half();
        chk({name, "_busy_end"}, {63'd0, busy}, 64'd0);
        chk({name, "_cmd_ready_end"}, {63'd0, cmd_ready}, 64'd1);
        tick();
    endtask

    logic [41:0] snap;

    initial begin
        checks = 0; errors = 0; mode_cnt = 0; mode_key = 0; stalls = 0; mode_seen = 4'd0;
        rst_n = 1'b0; cmd_mode = 4'd0; cmd_empty = 1'b0; cmd_valid = 1'b0;
        in_data = 8'd0; in_type = D_NULL; in_last = 1'b0; in_final = 1'b0; in_valid = 1'b0;
        key_ready = 1'b1; bdi_ready = 1'b1; done = 1'b0;

        // ENC: key, nonce, AD (3 bytes, upper byte of the field never sent), message
        mk(0, 4, D_KEY, 32'h03020100, 0, 0, 32'h03020100, 4'hF, 0, 0);
        mk(1, 4, D_KEY, 32'h07060504, 0, 0, 32'h07060504, 4'hF, 0, 0);
        mk(2, 4, D_KEY, 32'h0B0A0908, 0, 0, 32'h0B0A0908, 4'hF, 0, 0);
        mk(3, 4, D_KEY, 32'h0F0E0D0C, 1, 0, 32'h0F0E0D0C, 4'hF, 0, 0);
        mk(4, 4, D_NONCE, 32'h13121110, 0, 0, 32'h13121110, 4'hF, 0, 0);
        mk(5, 4, D_NONCE, 32'h17161514, 0, 0, 32'h17161514, 4'hF, 0, 0);
        mk(6, 4, D_NONCE, 32'h1B1A1918, 0, 0, 32'h1B1A1918, 4'hF, 0, 0);
        mk(7, 4, D_NONCE, 32'h1F1E1D1C, 1, 0, 32'h1F1E1D1C, 4'hF, 1, 0);
        mk(8, 3, D_AD, 32'hFFCCBBAA, 1, 0, 32'h00CCBBAA, 4'b0111, 1, 0);
        mk(9, 4, D_MSG, 32'h04030201, 1, 1, 32'h04030201, 4'hF, 1, 1);
        // DEC: key, nonce, then tag after a hand-driven message
        mk(10, 4, D_KEY, 32'h43424140, 0, 0, 32'h43424140, 4'hF, 0, 0);
        mk(11, 4, D_KEY, 32'h47464544, 0, 0, 32'h47464544, 4'hF, 0, 0);
        mk(12, 4, D_KEY, 32'h4B4A4948, 0, 0, 32'h4B4A4948, 4'hF, 0, 0);
        mk(13, 4, D_KEY, 32'h4F4E4D4C, 1, 0, 32'h4F4E4D4C, 4'hF, 0, 0);
        mk(14, 4, D_NONCE, 32'h53525150, 0, 0, 32'h53525150, 4'hF, 0, 0);
        mk(15, 4, D_NONCE, 32'h57565554, 0, 0, 32'h57565554, 4'hF, 0, 0);
        mk(16, 4, D_NONCE, 32'h5B5A5958, 0, 0, 32'h5B5A5958, 4'hF, 0, 0);
        mk(17, 4, D_NONCE, 32'h5F5E5D5C, 1, 0, 32'h5F5E5D5C, 4'hF, 1, 0);
        mk(18, 4, D_TAG, 32'h83828180, 0, 0, 32'h83828180, 4'hF, 0, 0);
        mk(19, 4, D_TAG, 32'h87868584, 0, 0, 32'h87868584, 4'hF, 0, 0);
        mk(20, 4, D_TAG, 32'h8B8A8988, 0, 0, 32'h8B8A8988, 4'hF, 0, 0);
        mk(21, 4, D_TAG, 32'h8F8E8D8C, 1, 1, 32'h8F8E8D8C, 4'hF, 1, 1);
        // After a mid-operation reset
        mk(22, 4, D_KEY, 32'h63626160, 1, 0, 32'h63626160, 4'hF, 0, 0);
        mk(23, 1, D_MSG, 32'hFFFFFF5A, 1, 1, 32'h0000005A, 4'b0001, 1, 1);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        // A byte offered while idle must not be taken
        in_valid = 1'b1; in_data = 8'h99; in_type = D_KEY;
        half();
        chk("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_mode", {60'd0, mode}, 64'd0);
        chk("rst_key_valid", {63'd0, key_valid}, 64'd0);
        chk("rst_bdi_valid", {60'd0, bdi_valid}, 64'd0);
        chk("rst_bdi_type", {60'd0, bdi_type}, {60'd0, D_NULL});
        chk("rst_eot_eoi", {62'd0, bdi_eot, bdi_eoi}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_state", {62'd0, dbg_state}, {62'd0, S_IDLE});
        tick();
        in_valid = 1'b0;

        // ENC through the vector table
        send_cmd(M_ENC, 1'b0);
        apply_vecs(0, 9);
        wait_drain();
        chk("enc_mode_pulses", 64'(mode_cnt), 64'd1);
        chk("enc_mode_with_key", 64'(mode_key), 64'd1);
        chk("enc_mode_value", {60'd0, mode_seen}, {60'd0, M_ENC});
        chk("enc_no_stalls", 64'(stalls), 64'd0);
        // A command during WAIT_DONE is ignored
        cmd_mode = M_HASH; cmd_empty = 1'b1; cmd_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            half();
            chk("wait_cmd_ready", {63'd0, cmd_ready}, 64'd0);
            chk("wait_state", {62'd0, dbg_state}, {62'd0, S_WAIT_DONE});
            tick();
        end
        cmd_valid = 1'b0;
        chk("wait_busy", {63'd0, busy}, 64'd1);
        finish_op("enc");

        // DEC with a stalled message word
        done = 1'b0; mode_cnt = 0; mode_key = 0;
        send_cmd(M_DEC, 1'b0);
        apply_vecs(10, 17);
        wait_drain();
        bdi_ready = 1'b0;
        exp_q.push_back({D_MSG, 1'b0, 1'b0, 4'hF, 32'h24232221});
        exp_q.push_back({D_MSG, 1'b1, 1'b0, 4'b0011, 32'h00002625});
        send_byte(8'h21, D_MSG, 0, 0);
        send_byte(8'h22, D_MSG, 0, 0);
        send_byte(8'h23, D_MSG, 0, 0);
        send_byte(8'h24, D_MSG, 0, 0);
        half();
        chk("latency_word", {22'd0, bdi_type, bdi_eot, bdi_eoi, bdi_valid, bdi},
            {22'd0, D_MSG, 1'b0, 1'b0, 4'hF, 32'h24232221});
        tick();
        send_byte(8'h25, D_MSG, 0, 0);
        send_byte(8'h26, D_MSG, 1, 0);
        snap = {bdi_type, bdi_eot, bdi_eoi, bdi_valid, bdi};
        for (int i = 0; i < 10; i++) begin
            half();
            chk("stall_stable", {22'd0, bdi_type, bdi_eot, bdi_eoi, bdi_valid, bdi}, {22'd0, snap});
            chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            tick();
        end
        bdi_ready = 1'b1;
        apply_vecs(18, 21);
        wait_drain();
        chk("dec_mode_pulses", 64'(mode_cnt), 64'd1);
        chk("dec_mode_with_key", 64'(mode_key), 64'd1);
        chk("dec_mode_value", {60'd0, mode_seen}, {60'd0, M_DEC});
        finish_op("dec");

        // Empty HASH; done is still high from the previous operation
        mode_cnt = 0;
        send_cmd(M_HASH, 1'b1);
        half();
        chk("empty_mode", {60'd0, mode}, {60'd0, M_HASH});
        chk("empty_eoi", {63'd0, bdi_eoi}, 64'd1);
        chk("empty_bdi_valid", {60'd0, bdi_valid}, 64'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            half();
            tick();
        end
        chk("empty_busy_held", {63'd0, busy}, 64'd1);
        chk("empty_mode_pulses", 64'(mode_cnt), 64'd1);
        done = 1'b0;
        half(); tick();
        half(); tick();
        finish_op("hash");

        // Reset during STREAM with two key bytes assembled
        done = 1'b0; mode_cnt = 0; mode_key = 0;
        send_cmd(M_ENC, 1'b0);
        send_byte(8'hEE, D_KEY, 0, 0);
        send_byte(8'hEF, D_KEY, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
        chk("arst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("arst_outputs", {57'd0, key_valid, bdi_valid, mode != 4'd0, bdi_eoi}, 64'd0);
        chk("arst_state", {62'd0, dbg_state}, {62'd0, S_IDLE});
        half();
        rst_n = 1'b1;
        tick();
        mode_cnt = 0; mode_key = 0;
        send_cmd(M_ENC, 1'b0);
        apply_vecs(22, 23);
        wait_drain();
        chk("post_rst_mode_pulses", 64'(mode_cnt), 64'd1);
        chk("post_rst_mode_with_key", 64'(mode_key), 64'd1);
        finish_op("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
